// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sched_pkg
//  Purpose  : Shared types and constants for the round-robin FIFO read scheduler.
//  Revision : 1.0
// ============================================================================
package fifo_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    localparam int BUF_DEPTH = 2;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational rotate-priority encoder; search starts at ptr+1.
//  Revision : 1.0
// ============================================================================
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int pN = 4,
    parameter int pW = ch_w(pN)
) (
    input  logic [pN-1:0] req,
    input  logic [pW-1:0] ptr,
    output logic [pW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [pW-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = '0;
        for (int i = pN; i >= 1; i--) begin
            w_idx = pW'((int'(ptr) + i) % pN);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_scheduler
//  Purpose  : Round-robin burst reader draining channel FIFOs into one stream.
//  Revision : 1.0
// ============================================================================
module fifo_rd_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int pNUM_CH     = 4,
    parameter int pDATA_WIDTH = 8,
    parameter int pBURST      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [pNUM_CH-1:0]             fifo_empty,
    output logic [pNUM_CH-1:0]             fifo_rd_en,
    input  logic [pNUM_CH*pDATA_WIDTH-1:0] fifo_rd_data,
    input  logic [pNUM_CH-1:0]             fifo_valid,
    output logic [pDATA_WIDTH-1:0]         m_data,
    output logic [$clog2(pNUM_CH)-1:0]     m_ch,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           busy
);

    localparam int CH_W   = ch_w(pNUM_CH);
    localparam int BEAT_W = (pBURST > 1) ? $clog2(pBURST) : 1;

    localparam logic [0:0]        c_ST_IDLE   = 1'(IDLE);
    localparam logic [0:0]        c_ST_READ   = 1'(READ);
    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(pBURST - 1);

    logic [0:0]        r_state;
    logic [CH_W-1:0]   r_gnt;
    logic [CH_W-1:0]   r_ptr;
    logic [BEAT_W-1:0] r_beat;
    logic              r_infl;
    logic [CH_W-1:0]   r_tag;

    logic [pDATA_WIDTH-1:0] r_buf_data [BUF_DEPTH];
    logic [CH_W-1:0]        r_buf_ch   [BUF_DEPTH];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_occ;

    logic [CH_W-1:0] w_arb_idx;
    logic            w_arb_vld;
    logic            w_ret;
    logic            w_pop;
    logic [1:0]      w_pend;
    logic            w_credit;
    logic            w_issue;

    rr_arbiter #(
        .pN (pNUM_CH),
        .pW (CH_W)
    ) u_arb (
        .req     (~fifo_empty),
        .ptr     (r_ptr),
        .gnt_idx (w_arb_idx),
        .gnt_vld (w_arb_vld)
    );

    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_buf_data[r_rd_ptr];
    assign m_ch    = r_buf_ch[r_rd_ptr];
    assign busy    = (r_state == c_ST_READ) || r_infl || (r_occ != 2'd0);

    // Returned data is accepted only for the single outstanding read.
    assign w_ret    = r_infl && fifo_valid[r_tag];
    assign w_pop    = m_valid && m_ready;
    assign w_pend   = r_occ + 2'(r_infl);
    assign w_credit = (w_pend < 2'd2) || ((w_pend == 2'd2) && w_pop);
    assign w_issue  = (r_state == c_ST_READ) && !fifo_empty[r_gnt] && w_credit;

    always_comb begin
        fifo_rd_en = '0;
        if (w_issue) begin
            fifo_rd_en[r_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (en && w_arb_vld) begin
                        r_state <= c_ST_READ;
                        r_gnt   <= w_arb_idx;
                        r_ptr   <= w_arb_idx;
                        r_beat  <= '0;
                    end
                end
                c_ST_READ: begin
                    if (w_credit && fifo_empty[r_gnt]) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_issue) begin
                        if (r_beat == c_LAST_BEAT) begin
                            r_state <= c_ST_IDLE;
                        end
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_infl   <= 1'b0;
            r_tag    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_ch[i]   <= '0;
            end
        end else begin
            if (w_issue) begin
                r_tag  <= r_gnt;
                r_infl <= 1'b1;
            end else if (w_ret) begin
                r_infl <= 1'b0;
            end
            if (w_ret) begin
                r_buf_data[r_wr_ptr] <= fifo_rd_data[r_tag*pDATA_WIDTH +: pDATA_WIDTH];
                r_buf_ch[r_wr_ptr]   <= r_tag;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_ret, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire
